// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache miss controller.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_FILL   = 2'd2,
        ST_COMMIT = 2'd3
    } miss_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/icache_refill_timer.sv
// Refill watchdog: down-counter loaded on clear, decremented while enabled,
// flags expiry on the enabled cycle that reaches terminal count.
module icache_refill_timer
    import icache_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic srst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int            TW   = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LOAD = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = LOAD;
        end else if (enable_i) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The TIMEOUT_CYCLES-th idle cycle is the one that expires.
    assign expired_o = enable_i & ~clear_i & (cnt_q == TW'(1));

endmodule

// File: rtl/icache_miss_ctrl.sv
// Instruction-cache miss controller: requests a line, writes beats critical-word
// first, commits the tag, and retries or reports on error/timeout.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | no miss outstanding, lookups accepted
// ST_REQ    | line request presented to memory
// ST_FILL   | receiving beats, refill timer running
// ST_COMMIT | all beats written, tag/valid update this cycle
module icache_miss_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W         = 30,
    parameter int LINE_WORDS     = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 2
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          i_halt,
    input  logic                          i_valid,
    input  logic                          i_cache_hit,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic                          o_ready,
    output logic                          o_miss_state,
    output logic                          o_error,
    output logic                          o_mem_req_valid,
    input  logic                          i_mem_req_ready,
    output logic [ADDR_W-1:0]             o_mem_req_addr,
    input  logic                          i_mem_rsp_valid,
    input  logic                          i_mem_rsp_err,
    output logic                          o_mem_rsp_ready,
    output logic                          o_array_wr_en,
    output logic [$clog2(LINE_WORDS)-1:0] o_array_wr_idx,
    output logic                          o_send_missed_word,
    output logic                          o_tag_wr_en
);

    localparam int                 OFF_W     = $clog2(LINE_WORDS);
    localparam int                 RETRY_W   = cnt_width(MAX_RETRY);
    localparam logic [OFF_W-1:0]   LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    miss_state_e         state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [OFF_W-1:0]    beat_q, beat_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;

    logic run;
    logic req_fire;
    logic beat_acc, beat_err, beat_ok;
    logic timer_clr, timer_en, timer_exp;
    logic abort;

    assign run       = ~srst & ~i_halt;
    assign req_fire  = (state_q == ST_REQ) & i_mem_req_ready & run;
    assign beat_acc  = (state_q == ST_FILL) & run & i_mem_rsp_valid;
    assign beat_err  = beat_acc & i_mem_rsp_err;
    assign beat_ok   = beat_acc & ~i_mem_rsp_err;
    assign timer_clr = req_fire | beat_acc;
    assign timer_en  = (state_q == ST_FILL) & run & ~beat_acc;
    assign abort     = beat_err | timer_exp;

    icache_refill_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .srst     (srst),
        .clear_i  (timer_clr),
        .enable_i (timer_en),
        .expired_o(timer_exp)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        retry_d     = retry_q;
        o_error     = 1'b0;
        o_tag_wr_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (run & i_valid & ~i_cache_hit) begin
                    addr_d  = i_addr;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (req_fire) begin
                    beat_d  = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                // Abort wins over completing on the last beat.
                if (abort) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_REQ;
                    end else begin
                        o_error = 1'b1;
                        retry_d = '0;
                        state_d = ST_IDLE;
                    end
                end else if (beat_ok) begin
                    beat_d = beat_q + OFF_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                if (run) begin
                    o_tag_wr_en = 1'b1;
                    retry_d     = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            retry_q <= '0;
        end else if (!i_halt) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            retry_q <= retry_d;
        end
    end

    // Level outputs are masked during reset so a cycle of srst looks idle.
    assign o_ready            = ~i_halt & (srst | (state_q == ST_IDLE));
    assign o_miss_state       = ~srst & (state_q != ST_IDLE);
    assign o_mem_req_valid    = ~srst & (state_q == ST_REQ);
    assign o_mem_req_addr     = o_mem_req_valid ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign o_mem_rsp_ready    = run & (state_q == ST_FILL);
    assign o_array_wr_en      = beat_ok;
    assign o_array_wr_idx     = srst ? '0 : (addr_q[OFF_W-1:0] + beat_q);
    assign o_send_missed_word = beat_ok & (beat_q == '0);

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Directed bench for icache_miss_ctrl with LINE_WORDS=4, TIMEOUT_CYCLES=8, MAX_RETRY=1.
module tb_icache_miss_ctrl;

    logic        clk;
    logic        srst;
    logic        i_halt;
    logic        i_valid;
    logic        i_cache_hit;
    logic [29:0] i_addr;
    logic        o_ready;
    logic        o_miss_state;
    logic        o_error;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [29:0] o_mem_req_addr;
    logic        i_mem_rsp_valid;
    logic        i_mem_rsp_err;
    logic        o_mem_rsp_ready;
    logic        o_array_wr_en;
    logic [1:0]  o_array_wr_idx;
    logic        o_send_missed_word;
    logic        o_tag_wr_en;

    int n_cmp = 0;
    int n_bad = 0;

    icache_miss_ctrl #(
        .ADDR_W(30), .LINE_WORDS(4), .TIMEOUT_CYCLES(8), .MAX_RETRY(1)
    ) dut (
        .clk(clk), .srst(srst), .i_halt(i_halt), .i_valid(i_valid),
        .i_cache_hit(i_cache_hit), .i_addr(i_addr), .o_ready(o_ready),
        .o_miss_state(o_miss_state), .o_error(o_error),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
        .o_mem_req_addr(o_mem_req_addr), .i_mem_rsp_valid(i_mem_rsp_valid),
        .i_mem_rsp_err(i_mem_rsp_err), .o_mem_rsp_ready(o_mem_rsp_ready),
        .o_array_wr_en(o_array_wr_en), .o_array_wr_idx(o_array_wr_idx),
        .o_send_missed_word(o_send_missed_word), .o_tag_wr_en(o_tag_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr_in();
        i_halt          = 1'b0;
        i_valid         = 1'b0;
        i_cache_hit     = 1'b0;
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_err   = 1'b0;
    endtask

    // Miss in IDLE, then REQ with immediate handshake; state is FILL afterwards.
    task automatic start_miss(input logic [29:0] a, input logic [29:0] line);
        @(negedge clk); clr_in(); i_valid = 1'b1; i_addr = a;
        #1 check("miss_ready", 32'(o_ready), 1);
        @(negedge clk); clr_in(); i_mem_req_ready = 1'b1;
        #1 check("req_valid", 32'(o_mem_req_valid), 1);
        check("req_addr", 32'(o_mem_req_addr), 32'(line));
        check("req_busy", 32'(o_ready), 0);
    endtask

    task automatic beat(input int idx, input int first);
        @(negedge clk); clr_in(); i_mem_rsp_valid = 1'b1;
        #1 check("wr_en", 32'(o_array_wr_en), 1);
        check("wr_idx", 32'(o_array_wr_idx), 32'(idx));
        check("send_word", 32'(o_send_missed_word), 32'(first));
        check("beat_err", 32'(o_error), 0);
    endtask

    task automatic idle_fill(input int n, input int err_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); clr_in();
            #1 check("fill_rsp_ready", 32'(o_mem_rsp_ready), 1);
            check("fill_err", 32'(o_error), (i == n - 1) ? 32'(err_last) : 0);
            check("fill_tag", 32'(o_tag_wr_en), 0);
        end
    endtask

    task automatic commit_chk();
        @(negedge clk); clr_in();
        #1 check("tag_wr", 32'(o_tag_wr_en), 1);
        check("commit_err", 32'(o_error), 0);
        @(negedge clk); clr_in();
        #1 check("tag_once", 32'(o_tag_wr_en), 0);
        check("back_idle", 32'(o_miss_state), 0);
        check("back_ready", 32'(o_ready), 1);
    endtask

    initial begin
        srst = 1'b1; i_addr = '0; clr_in(); i_halt = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check("rst_ready_halt", 32'(o_ready), 0);
        check("rst_miss", 32'(o_miss_state), 0);
        i_halt = 1'b0;
        #1 check("rst_ready", 32'(o_ready), 1);
        check("rst_req", 32'(o_mem_req_valid), 0);
        check("rst_tag", 32'(o_tag_wr_en), 0);
        check("rst_err", 32'(o_error), 0);
        @(negedge clk); srst = 1'b0;

        // Hit: no state change, no request
        @(negedge clk); clr_in(); i_valid = 1'b1; i_cache_hit = 1'b1; i_addr = 30'h55;
        #1 check("hit_ready", 32'(o_ready), 1);
        @(negedge clk); clr_in();
        #1 check("hit_idle", 32'(o_miss_state), 0);
        check("hit_noreq", 32'(o_mem_req_valid), 0);

        // Clean refill, critical word first
        start_miss(30'h13, 30'h10);
        beat(3, 1); beat(0, 0); beat(1, 0); beat(2, 0);
        commit_chk();

        // Error on beat count 2, one retry, then clean refill
        start_miss(30'h13, 30'h10);
        beat(3, 1); beat(0, 0);
        @(negedge clk); clr_in(); i_mem_rsp_valid = 1'b1; i_mem_rsp_err = 1'b1;
        #1 check("errbeat_wr", 32'(o_array_wr_en), 0);
        check("errbeat_send", 32'(o_send_missed_word), 0);
        check("errbeat_noerr", 32'(o_error), 0);
        @(negedge clk); clr_in(); i_mem_req_ready = 1'b1; i_mem_rsp_valid = 1'b1;
        #1 check("retry_req", 32'(o_mem_req_valid), 1);
        check("retry_addr", 32'(o_mem_req_addr), 32'h10);
        check("req_rsp_ignored", 32'(o_mem_rsp_ready), 0);
        check("req_no_wr", 32'(o_array_wr_en), 0);
        beat(3, 1); beat(0, 0); beat(1, 0); beat(2, 0);
        commit_chk();

        // Two timeouts: retry once, then error
        start_miss(30'h22, 30'h20);
        idle_fill(8, 0);
        @(negedge clk); clr_in(); i_mem_req_ready = 1'b1;
        #1 check("to_retry_req", 32'(o_mem_req_valid), 1);
        idle_fill(8, 1);
        @(negedge clk); clr_in();
        #1 check("to_idle", 32'(o_miss_state), 0);
        check("to_err_once", 32'(o_error), 0);
        check("to_ready", 32'(o_ready), 1);

        // Halt mid-fill freezes beat and timer; halt in COMMIT holds the tag write
        start_miss(30'h31, 30'h30);
        beat(1, 1); beat(2, 0);
        idle_fill(5, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); clr_in(); i_halt = 1'b1; i_mem_rsp_valid = 1'b1;
            #1 check("halt_rsp_ready", 32'(o_mem_rsp_ready), 0);
            check("halt_wr", 32'(o_array_wr_en), 0);
            check("halt_ready", 32'(o_ready), 0);
            check("halt_miss", 32'(o_miss_state), 1);
        end
        idle_fill(2, 0);
        beat(3, 0); beat(0, 0);
        @(negedge clk); clr_in(); i_halt = 1'b1;
        #1 check("halt_commit_tag", 32'(o_tag_wr_en), 0);
        commit_chk();

        // Reset mid-fill after a retry; next miss starts with retry count 0
        start_miss(30'h13, 30'h10);
        beat(3, 1);
        @(negedge clk); clr_in(); i_mem_rsp_valid = 1'b1; i_mem_rsp_err = 1'b1;
        #1 check("pre_rst_err", 32'(o_error), 0);
        @(negedge clk); clr_in(); i_mem_req_ready = 1'b1;
        #1 check("pre_rst_req", 32'(o_mem_req_valid), 1);
        beat(3, 1); beat(0, 0);
        @(negedge clk); clr_in(); srst = 1'b1; i_mem_rsp_valid = 1'b1;
        #1 check("srst_wr", 32'(o_array_wr_en), 0);
        check("srst_rsp_ready", 32'(o_mem_rsp_ready), 0);
        check("srst_miss", 32'(o_miss_state), 0);
        check("srst_ready", 32'(o_ready), 1);
        check("srst_tag", 32'(o_tag_wr_en), 0);
        check("srst_err", 32'(o_error), 0);
        @(negedge clk); clr_in(); srst = 1'b0;
        #1 check("post_rst_idle", 32'(o_miss_state), 0);
        check("post_rst_ready", 32'(o_ready), 1);
        start_miss(30'h06, 30'h04);
        idle_fill(8, 0);
        @(negedge clk); clr_in(); i_mem_req_ready = 1'b1;
        #1 check("post_rst_retry", 32'(o_mem_req_valid), 1);
        check("post_rst_addr", 32'(o_mem_req_addr), 32'h04);
        beat(2, 1); beat(3, 0); beat(0, 0); beat(1, 0);
        commit_chk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
